// File: rtl/lsu_ext_req_queue.sv
// rtl/lsu_ext_req_queue.sv - in-order external LSU request queue with single outstanding load
// Optional LSU_EXTQ_LD_ALIGN_EN: align, truncate and extend load data before returning it to the LSU.
module lsu_ext_req_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [1:0]  in_size,
   input  logic        in_unsign,
   input  logic        in_store,
   input  logic        in_sideeffect,
   input  logic        in_fault,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [1:0]  bus_size,
   output logic        bus_write,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_data,
   input  logic        bus_rsp_err,
   output logic        ld_rsp_valid,
   output logic [31:0] ld_rsp_data,
   output logic        ld_rsp_err,
   output logic        q_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      addr_q  [DEPTH];
   logic [31:0]      wdata_q [DEPTH];
   logic [1:0]       size_q  [DEPTH];
   logic [DEPTH-1:0] unsign_q;
   logic [DEPTH-1:0] store_q;
   logic [DEPTH-1:0] se_q;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             ld_outstanding;

   logic             full;
   logic             push;
   logic             pop;
   logic             head_store;
   logic             head_se;
   logic             block;
   logic             rsp_take;

   logic [1:0]       lat_off;
   logic [1:0]       lat_size;
   logic             lat_unsign;
   logic [31:0]      rsp_word;

   assign full       = (count == CNT_W'(DEPTH));
   assign in_ready   = ~full;
   assign push       = in_valid & in_ready & ~in_fault;

   assign head_store = store_q[rd_ptr];
   assign head_se    = se_q[rd_ptr];
   // A store may overtake an outstanding load unless it has side effects.
   assign block      = ld_outstanding & (~head_store | head_se);
   assign bus_valid  = (count != '0) & ~block;
   assign bus_addr   = addr_q[rd_ptr];
   assign bus_wdata  = wdata_q[rd_ptr];
   assign bus_size   = size_q[rd_ptr];
   assign bus_write  = head_store;
   assign pop        = bus_valid & bus_ready;

   assign rsp_take   = bus_rsp_valid & ld_outstanding;
   assign q_empty    = (count == '0) & ~ld_outstanding & ~ld_rsp_valid;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr]   <= in_addr;
         wdata_q[wr_ptr]  <= in_wdata;
         size_q[wr_ptr]   <= in_size;
         unsign_q[wr_ptr] <= in_unsign;
         store_q[wr_ptr]  <= in_store;
         se_q[wr_ptr]     <= in_sideeffect;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         ld_outstanding <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // A load pop is impossible while a load is outstanding, so set and clear never collide.
         if (pop & ~head_store)
            ld_outstanding <= 1'b1;
         else if (rsp_take)
            ld_outstanding <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_off    <= 2'd0;
         lat_size   <= 2'd0;
         lat_unsign <= 1'b0;
      end else if (pop & ~head_store) begin
         lat_off    <= bus_addr[1:0];
         lat_size   <= bus_size;
         lat_unsign <= unsign_q[rd_ptr];
      end
   end

`ifdef LSU_EXTQ_LD_ALIGN_EN
   logic [31:0] shifted;

   always_comb begin
      shifted = bus_rsp_data >> {lat_off, 3'b000};
      case (lat_size)
         2'd0:    rsp_word = {{24{~lat_unsign & shifted[7]}}, shifted[7:0]};
         2'd1:    rsp_word = {{16{~lat_unsign & shifted[15]}}, shifted[15:0]};
         default: rsp_word = shifted;
      endcase
   end
`else
   logic unused_lat;

   assign unused_lat = ^{lat_off, lat_size, lat_unsign};
   assign rsp_word   = bus_rsp_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_rsp_valid <= 1'b0;
         ld_rsp_data  <= 32'd0;
         ld_rsp_err   <= 1'b0;
      end else begin
         ld_rsp_valid <= rsp_take;
         if (rsp_take) begin
            ld_rsp_data <= rsp_word;
            ld_rsp_err  <= bus_rsp_err;
         end
      end
   end

endmodule
